// File: rtl/synapse_frame_loader.sv
// Byte-stream front end for neuron_lif: assembles weight and input vectors from a
// valid/ready byte stream and issues one neuron_enable strobe per completed input vector.
module synapse_frame_loader #(
    parameter int SYNAPSES = 32,
    parameter int TS_BITS  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_data,
    input  logic                in_kind,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                abort,
    input  logic                hold,
    output logic [SYNAPSES-1:0] weights,
    output logic [SYNAPSES-1:0] inputs,
    output logic                neuron_enable,
    output logic                weights_valid,
    output logic [TS_BITS-1:0]  timestep
);
    localparam int BYTES    = SYNAPSES / 8;
    localparam int CNT_BITS = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_BITS-1:0] LAST_BYTE = CNT_BITS'(BYTES - 1);

    localparam logic [0:0] ASSEMBLE = 1'b0;
    localparam logic [0:0] FIRE     = 1'b1;

    logic [0:0]          state;
    logic [CNT_BITS-1:0] w_cnt;
    logic [CNT_BITS-1:0] x_cnt;
    logic [SYNAPSES-1:0] w_stage;
    logic [SYNAPSES-1:0] x_stage;
    logic [SYNAPSES-1:0] w_next;
    logic [SYNAPSES-1:0] x_next;
    logic                accept;
    logic                w_accept;
    logic                x_accept;

    // Reset gates in_ready so nothing is offered as accepted while reset is held.
    assign in_ready      = (state == ASSEMBLE) & ~abort & ~reset;
    assign neuron_enable = (state == FIRE) & ~hold;
    assign accept        = in_valid & in_ready;
    assign w_accept      = accept & in_kind;
    assign x_accept      = accept & ~in_kind;

    // Staging vectors with the byte currently on in_data merged in, so the commit
    // edge captures the complete vector including the final byte.
    always_comb begin
        // NOTE: defaults first, then overrides -- every path assigns, so no latch is inferred.
        w_next = w_stage;
        x_next = x_stage;
        for (int k = 0; k < BYTES; k++) begin
            if (w_cnt == CNT_BITS'(k)) w_next[8*k +: 8] = in_data;
            if (x_cnt == CNT_BITS'(k)) x_next[8*k +: 8] = in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state and datapath registers are all cleared asynchronously; outputs are
        // defined the moment reset rises, and the sequential updates use <= throughout.
        if (reset) begin
            state         <= ASSEMBLE;
            w_cnt         <= '0;
            x_cnt         <= '0;
            w_stage       <= '0;
            x_stage       <= '0;
            weights       <= '0;
            inputs        <= '0;
            weights_valid <= 1'b0;
            timestep      <= '0;
        end else begin
            if (neuron_enable) begin
                state    <= ASSEMBLE;
                timestep <= timestep + TS_BITS'(1);
            end

            if (abort) begin
                w_cnt   <= '0;
                x_cnt   <= '0;
                w_stage <= '0;
                x_stage <= '0;
            end else begin
                if (w_accept) begin
                    w_stage <= w_next;
                    if (w_cnt == LAST_BYTE) begin
                        weights       <= w_next;
                        weights_valid <= 1'b1;
                        w_cnt         <= '0;
                    end else begin
                        w_cnt <= w_cnt + CNT_BITS'(1);
                    end
                end
                // Accepts only happen in ASSEMBLE, so this never collides with the FIRE exit above.
                if (x_accept) begin
                    x_stage <= x_next;
                    if (x_cnt == LAST_BYTE) begin
                        inputs <= x_next;
                        x_cnt  <= '0;
                        state  <= FIRE;
                    end else begin
                        x_cnt <= x_cnt + CNT_BITS'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_synapse_frame_loader.sv
// Self-checking bench for synapse_frame_loader: directed table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_synapse_frame_loader;
    localparam int SYN   = 32;
    localparam int NB    = SYN / 8;
    localparam int TSMOD = 65536;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      in_data;
    logic            in_kind, in_valid, abort, hold;
    logic            in_ready, neuron_enable, weights_valid;
    logic [SYN-1:0]  weights, inputs;
    logic [15:0]     timestep;

    // Second instance: one-byte vectors and a 4-bit timestep to reach the wrap quickly.
    logic [7:0] in_data2, weights2, inputs2;
    logic       in_kind2, in_valid2, abort2, hold2, ready2, en2, wv2;
    logic [3:0] ts2;

    always #5 clk = ~clk;

    synapse_frame_loader #(.SYNAPSES(SYN), .TS_BITS(16)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_kind(in_kind),
        .in_valid(in_valid), .in_ready(in_ready), .abort(abort), .hold(hold),
        .weights(weights), .inputs(inputs), .neuron_enable(neuron_enable),
        .weights_valid(weights_valid), .timestep(timestep)
    );

    synapse_frame_loader #(.SYNAPSES(8), .TS_BITS(4)) dut_b1 (
        .clk(clk), .reset(reset), .in_data(in_data2), .in_kind(in_kind2),
        .in_valid(in_valid2), .in_ready(ready2), .abort(abort2), .hold(hold2),
        .weights(weights2), .inputs(inputs2), .neuron_enable(en2),
        .weights_valid(wv2), .timestep(ts2)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queues per kind, a pending-timestep flag and a counter.
    byte unsigned    wq[$];
    byte unsigned    xq[$];
    logic [SYN-1:0]  m_w, m_x;
    bit              m_wv, m_pending;
    int              m_ts;

    function automatic logic [SYN-1:0] pack(input byte unsigned q[$]);
        logic [SYN-1:0] v = '0;
        foreach (q[i]) v = v | (SYN'(q[i]) << (8 * i));
        return v;
    endfunction

    task automatic model_reset();
        wq.delete(); xq.delete();
        m_w = '0; m_x = '0; m_wv = 0; m_pending = 0; m_ts = 0;
    endtask

    task automatic model_edge(input logic v, k, input logic [7:0] d, input logic a, h);
        bit take;
        take = v && !m_pending && !a;
        if (m_pending && !h) begin
            m_pending = 0;
            m_ts = (m_ts + 1) % TSMOD;
        end
        if (a) begin
            wq.delete(); xq.delete();
        end else if (take) begin
            if (k) begin
                wq.push_back(d);
                if (wq.size() == NB) begin m_w = pack(wq); m_wv = 1; wq.delete(); end
            end else begin
                xq.push_back(d);
                if (xq.size() == NB) begin m_x = pack(xq); m_pending = 1; xq.delete(); end
            end
        end
    endtask

    // Snapshot of DUT outputs from the most recent cycle.
    logic           s_ready, s_en, s_wv;
    logic [SYN-1:0] s_w, s_x;
    logic [15:0]    s_ts;

    // One clock: drive after the edge, observe at negedge, advance the model at posedge.
    task automatic cycle(input logic v, k, input logic [7:0] d, input logic a, h);
        in_valid = v; in_kind = k; in_data = d; abort = a; hold = h;
        @(negedge clk);
        s_ready = in_ready; s_en = neuron_enable; s_wv = weights_valid;
        s_w = weights; s_x = inputs; s_ts = timestep;
        check("in_ready", 64'(in_ready), 64'(!m_pending && !a));
        check("neuron_enable", 64'(neuron_enable), 64'(m_pending && !h));
        check("weights", 64'(weights), 64'(m_w));
        check("inputs", 64'(inputs), 64'(m_x));
        check("weights_valid", 64'(weights_valid), 64'(m_wv));
        check("timestep", 64'(timestep), 64'(m_ts));
        @(posedge clk);
        model_edge(v, k, d, a, h);
        #1;
    endtask

    task automatic idle(input int n, input logic h);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, h);
    endtask

    typedef struct {
        logic        v, k;
        logic [7:0]  d;
        logic        a, h;
        logic        exp_ready, exp_en, exp_wv;
        logic [31:0] exp_w, exp_x;
        logic [15:0] exp_ts;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(logic v, k, logic [7:0] d, logic a, logic r, logic e,
                                logic wv, logic [31:0] w, logic [31:0] x, logic [15:0] ts);
        vec_t t;
        t.v = v; t.k = k; t.d = d; t.a = a; t.h = 1'b0;
        t.exp_ready = r; t.exp_en = e; t.exp_wv = wv;
        t.exp_w = w; t.exp_x = x; t.exp_ts = ts;
        return t;
    endfunction

    initial begin
        logic [31:0] w_exp, x_exp;
        logic [7:0]  b;
        int          pulses;

        localparam logic [31:0] W1 = 32'h55AA00FF;
        localparam logic [31:0] X1 = 32'h04030201;
        tbl[0]  = mk(1, 1, 8'hFF, 0, 1, 0, 0, 0,  0,  0);
        tbl[1]  = mk(1, 1, 8'h00, 0, 1, 0, 0, 0,  0,  0);
        tbl[2]  = mk(1, 1, 8'hAA, 0, 1, 0, 0, 0,  0,  0);
        tbl[3]  = mk(1, 1, 8'h55, 0, 1, 0, 0, 0,  0,  0);
        tbl[4]  = mk(1, 0, 8'h01, 0, 1, 0, 1, W1, 0,  0);
        tbl[5]  = mk(1, 0, 8'h02, 0, 1, 0, 1, W1, 0,  0);
        tbl[6]  = mk(1, 0, 8'h03, 0, 1, 0, 1, W1, 0,  0);
        tbl[7]  = mk(1, 0, 8'h04, 0, 1, 0, 1, W1, 0,  0);
        tbl[8]  = mk(0, 0, 8'h00, 0, 0, 1, 1, W1, X1, 0);
        tbl[9]  = mk(0, 0, 8'h00, 0, 1, 0, 1, W1, X1, 1);
        tbl[10] = mk(1, 0, 8'hAA, 0, 1, 0, 1, W1, X1, 1);
        tbl[11] = mk(1, 0, 8'hBB, 0, 1, 0, 1, W1, X1, 1);
        tbl[12] = mk(1, 0, 8'hCC, 1, 0, 0, 1, W1, X1, 1);
        tbl[13] = mk(1, 0, 8'h10, 0, 1, 0, 1, W1, X1, 1);
        tbl[14] = mk(1, 0, 8'h20, 0, 1, 0, 1, W1, X1, 1);
        tbl[15] = mk(1, 0, 8'h30, 0, 1, 0, 1, W1, X1, 1);
        tbl[16] = mk(1, 0, 8'h40, 0, 1, 0, 1, W1, X1, 1);
        tbl[17] = mk(0, 0, 8'h00, 0, 0, 1, 1, W1, 32'h40302010, 1);
        tbl[18] = mk(0, 0, 8'h00, 0, 1, 0, 1, W1, 32'h40302010, 2);

        reset = 1'b1; in_valid = 0; in_kind = 0; in_data = 0; abort = 0; hold = 0;
        in_valid2 = 0; in_kind2 = 0; in_data2 = 0; abort2 = 0; hold2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_enable", 64'(neuron_enable), 64'(0));
        check("rst_weights", 64'(weights), 64'(0));
        check("rst_timestep", 64'(timestep), 64'(0));
        reset = 1'b0;

        // Directed table: weight load, input vector, abort recovery.
        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].k, tbl[i].d, tbl[i].a, tbl[i].h);
            check($sformatf("tbl%0d_ready", i), 64'(s_ready), 64'(tbl[i].exp_ready));
            check($sformatf("tbl%0d_en", i), 64'(s_en), 64'(tbl[i].exp_en));
            check($sformatf("tbl%0d_wv", i), 64'(s_wv), 64'(tbl[i].exp_wv));
            check($sformatf("tbl%0d_w", i), 64'(s_w), 64'(tbl[i].exp_w));
            check($sformatf("tbl%0d_x", i), 64'(s_x), 64'(tbl[i].exp_x));
            check($sformatf("tbl%0d_ts", i), 64'(s_ts), 64'(tbl[i].exp_ts));
        end

        // Hold for five cycles after the last input byte, then exactly one pulse.
        for (int i = 0; i < NB; i++) cycle(1'b1, 1'b0, 8'(i + 1), 1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
            check("hold_no_pulse", 64'(s_en), 64'(0));
            check("hold_inputs_stable", 64'(s_x), 64'(32'h04030201));
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("hold_release_pulse", 64'(s_en), 64'(1));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            pulses += int'(s_en);
        end
        check("hold_single_pulse", 64'(pulses), 64'(0));

        // Interleaved W,X,W,X,... stream.
        w_exp = '0; x_exp = '0;
        for (int i = 0; i < NB; i++) begin
            b = 8'($urandom); w_exp[8*i +: 8] = b;
            cycle(1'b1, 1'b1, b, 1'b0, 1'b0);
            b = 8'($urandom); x_exp[8*i +: 8] = b;
            cycle(1'b1, 1'b0, b, 1'b0, 1'b0);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("ilv_enable", 64'(s_en), 64'(1));
        check("ilv_weights", 64'(s_w), 64'(w_exp));
        check("ilv_inputs", 64'(s_x), 64'(x_exp));

        // Abort while a timestep is pending still issues it.
        for (int i = 0; i < NB; i++) cycle(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("abort_fire_pulse", 64'(s_en), 64'(1));
        idle(1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++)
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) == 0));
        idle(2, 1'b0);

        // Reset mid-vector: outputs clear immediately, no stale pulse afterwards.
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 64'(in_ready), 64'(0));
        check("mid_rst_weights", 64'(weights), 64'(0));
        check("mid_rst_inputs", 64'(inputs), 64'(0));
        check("mid_rst_wv", 64'(weights_valid), 64'(0));
        check("mid_rst_ts", 64'(timestep), 64'(0));
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        cycle(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
        idle(NB + 2, 1'b0);

        // Reset while a held timestep is pending: the pulse is dropped.
        for (int i = 0; i < NB - 1; i++) cycle(1'b1, 1'b0, 8'h5C, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("fire_held_en", 64'(s_en), 64'(0));
        hold = 1'b0;
        reset = 1'b1;
        #1;
        check("fire_rst_enable", 64'(neuron_enable), 64'(0));
        check("fire_rst_inputs", 64'(inputs), 64'(0));
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        idle(4, 1'b0);

        // One-byte vectors: every byte commits, timestep wraps 15 -> 0.
        for (int i = 0; i < 17; i++) begin
            in_valid2 = 1'b1; in_kind2 = 1'b0; in_data2 = 8'(i + 1);
            @(negedge clk);
            check("b1_ready", 64'(ready2), 64'(1));
            check("b1_en_idle", 64'(en2), 64'(0));
            @(posedge clk); #1 in_valid2 = 1'b0;
            @(negedge clk);
            check("b1_en", 64'(en2), 64'(1));
            check("b1_ready_fire", 64'(ready2), 64'(0));
            check("b1_inputs", 64'(inputs2), 64'(i + 1));
            @(posedge clk); #1;
            @(negedge clk);
            check("b1_ts", 64'(ts2), 64'((i + 1) % 16));
            @(posedge clk); #1;
        end
        in_valid2 = 1'b1; in_kind2 = 1'b1; in_data2 = 8'h5A;
        @(posedge clk); #1 in_valid2 = 1'b0;
        @(negedge clk);
        check("b1_weights", 64'(weights2), 64'(8'h5A));
        check("b1_wv", 64'(wv2), 64'(1));
        check("b1_w_no_en", 64'(en2), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
